trace_filter_multi_window: RTL and testbench

Next-generation instruction trace filter between the core's commit trace and the continuous-monitoring transmit path. It classifies each valid instruction as branch, jump, WFI, post-trap or post-interrupt, and keeps or drops it. It adds three things:
- runtime per-category enables;
- a programmable post-event window of N following instructions;
- saturating kept/dropped statistics counters.

Trap and interrupt detection uses wrap-safe HPM counter change detection.

---
 rtl/trace_filter_multi_window_if.sv | 53 +++++
 rtl/trace_filter_multi_window.sv | 164 ++++++++++++++++
 tb/tb_trace_filter_multi_window.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/trace_filter_multi_window_if.sv
`default_nettype none
// ============================================================================
// Module      : trace_filter_multi_window_if
// Description : Commit-trace side bundle for the multi-window trace filter.
// Revision    : 1.0 - initial release
// ============================================================================
interface trace_filter_multi_window_if #(
    parameter int INSTR_WIDTH       = 32,
    parameter int HPM_COUNTER_WIDTH = 64,
    parameter int WINDOW_WIDTH      = 4,
    parameter int STAT_WIDTH        = 32
);
    logic                         pc_valid;
    logic [INSTR_WIDTH-1:0]       instr;
    logic [HPM_COUNTER_WIDTH-1:0] trap_counter;
    logic [HPM_COUNTER_WIDTH-1:0] interrupt_counter;
    logic [4:0]                   cat_enable;
    logic [4:0]                   post_enable;
    logic [WINDOW_WIDTH-1:0]      post_count;
    logic                         stats_clear;
    logic                         drop_instr;
    logic [STAT_WIDTH-1:0]        kept_count;
    logic [STAT_WIDTH-1:0]        dropped_count;

    modport master (
        output pc_valid,
        output instr,
        output trap_counter,
        output interrupt_counter,
        output cat_enable,
        output post_enable,
        output post_count,
        output stats_clear,
        input  drop_instr,
        input  kept_count,
        input  dropped_count
    );

    modport slave (
        input  pc_valid,
        input  instr,
        input  trap_counter,
        input  interrupt_counter,
        input  cat_enable,
        input  post_enable,
        input  post_count,
        input  stats_clear,
        output drop_instr,
        output kept_count,
        output dropped_count
    );
endinterface
`default_nettype wire

// File: rtl/trace_filter_multi_window.sv
`default_nettype none
// ============================================================================
// Module      : trace_filter_multi_window
// Description : Classifies committed instructions and keeps/drops them, with
//               a programmable post-event window and saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_filter_multi_window #(
    parameter int INSTR_WIDTH       = 32,
    parameter int HPM_COUNTER_WIDTH = 64,
    parameter int WINDOW_WIDTH      = 4,
    parameter int STAT_WIDTH        = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    trace_filter_multi_window_if.slave  tf
);

    localparam logic [6:0]             BRANCH_OPCODE   = 7'b1100011;
    localparam logic [6:0]             JAL_OPCODE      = 7'b1101111;
    localparam logic [6:0]             JALR_OPCODE     = 7'b1100111;
    localparam logic [INSTR_WIDTH-1:0] WFI_INSTRUCTION = INSTR_WIDTH'(32'h1050_0073);
    localparam logic [STAT_WIDTH-1:0]  STAT_MAX        = '1;
    localparam logic [STAT_WIDTH-1:0]  STAT_ONE        = STAT_WIDTH'(1);
    localparam logic [WINDOW_WIDTH-1:0] WIN_ONE        = WINDOW_WIDTH'(1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [WINDOW_WIDTH-1:0]      window_cnt_q, window_cnt_d;
    logic                         trap_pending_q, trap_pending_d;
    logic                         irq_pending_q, irq_pending_d;
    logic                         primed_q;
    logic [HPM_COUNTER_WIDTH-1:0] trap_q;
    logic [HPM_COUNTER_WIDTH-1:0] irq_q;
    logic [STAT_WIDTH-1:0]        kept_q, kept_d;
    logic [STAT_WIDTH-1:0]        dropped_q, dropped_d;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [15:0] w_c;
    logic [6:0]  w_opcode;
    logic        w_is_comp;
    logic [2:0]  w_c_f3;
    logic [3:0]  w_c_f4;
    logic        w_branch;
    logic        w_jump;
    logic        w_wfi;
    logic        w_c_jr_jalr;

    assign w_c       = tf.instr[15:0];
    assign w_opcode  = tf.instr[6:0];
    assign w_is_comp = (w_c[1:0] != 2'b11);
    assign w_c_f3    = w_c[15:13];
    assign w_c_f4    = w_c[15:12];

    // C.JR / C.JALR: quadrant 2, funct4 100x, rs1 != 0, rs2 == 0
    assign w_c_jr_jalr = w_is_comp && (w_c[1:0] == 2'b10)
                       && ((w_c_f4 == 4'b1000) || (w_c_f4 == 4'b1001))
                       && (w_c[11:7] != 5'd0) && (w_c[6:2] == 5'd0);

    assign w_branch = (!w_is_comp && (w_opcode == BRANCH_OPCODE))
                    || (w_is_comp && (w_c[1:0] == 2'b01)
                        && ((w_c_f3 == 3'b110) || (w_c_f3 == 3'b111)));

    assign w_jump = (!w_is_comp && ((w_opcode == JAL_OPCODE) || (w_opcode == JALR_OPCODE)))
                  || (w_is_comp && (w_c[1:0] == 2'b01) && (w_c_f3 == 3'b001))
                  || w_c_jr_jalr;

    assign w_wfi = (tf.instr == WFI_INSTRUCTION);

    // ------------------------------------------------------------------
    // Keep / drop decision
    // ------------------------------------------------------------------
    logic [4:0]              w_ev_cat;
    logic                    w_keep;
    logic                    w_armed;
    logic [WINDOW_WIDTH-1:0] w_dec;
    logic [WINDOW_WIDTH-1:0] w_load;

    assign w_ev_cat = {irq_pending_q, trap_pending_q, w_wfi, w_jump, w_branch} & tf.cat_enable;
    assign w_keep   = (w_ev_cat != 5'd0) || (window_cnt_q != '0);
    assign w_armed  = ((w_ev_cat & tf.post_enable) != 5'd0);
    assign w_dec    = (window_cnt_q == '0) ? '0 : (window_cnt_q - WIN_ONE);
    // Overlapping events may only extend the remaining window
    assign w_load   = (w_dec > tf.post_count) ? w_dec : tf.post_count;

    assign tf.drop_instr    = tf.pc_valid & ~w_keep;
    assign tf.kept_count    = kept_q;
    assign tf.dropped_count = dropped_q;

    // ------------------------------------------------------------------
    // Counter change detection (inequality, so wrap-around is an event)
    // ------------------------------------------------------------------
    logic w_trap_change;
    logic w_irq_change;

    assign w_trap_change = primed_q && (tf.trap_counter != trap_q);
    assign w_irq_change  = primed_q && (tf.interrupt_counter != irq_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        window_cnt_d   = window_cnt_q;
        trap_pending_d = trap_pending_q;
        irq_pending_d  = irq_pending_q;
        kept_d         = kept_q;
        dropped_d      = dropped_q;

        if (tf.pc_valid) begin
            window_cnt_d   = w_armed ? w_load : w_dec;
            trap_pending_d = 1'b0;
            irq_pending_d  = 1'b0;
        end
        // A fresh change outranks consumption by the current instruction
        if (w_trap_change) begin
            trap_pending_d = 1'b1;
        end
        if (w_irq_change) begin
            irq_pending_d = 1'b1;
        end

        if (tf.stats_clear) begin
            kept_d    = '0;
            dropped_d = '0;
        end else if (tf.pc_valid) begin
            if (w_keep) begin
                if (kept_q != STAT_MAX) begin
                    kept_d = kept_q + STAT_ONE;
                end
            end else begin
                if (dropped_q != STAT_MAX) begin
                    dropped_d = dropped_q + STAT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_cnt_q   <= '0;
            trap_pending_q <= 1'b0;
            irq_pending_q  <= 1'b0;
            primed_q       <= 1'b0;
            trap_q         <= '0;
            irq_q          <= '0;
            kept_q         <= '0;
            dropped_q      <= '0;
        end else begin
            window_cnt_q   <= window_cnt_d;
            trap_pending_q <= trap_pending_d;
            irq_pending_q  <= irq_pending_d;
            primed_q       <= 1'b1;
            trap_q         <= tf.trap_counter;
            irq_q          <= tf.interrupt_counter;
            kept_q         <= kept_d;
            dropped_q      <= dropped_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trace_filter_multi_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_filter_multi_window
// Description : Directed self-checking bench for trace_filter_multi_window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_filter_multi_window;

    localparam int STAT_W = 4;

    localparam logic [31:0] BEQ   = 32'h0000_0063;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JAL   = 32'h0000_006F;
    localparam logic [31:0] WFI   = 32'h1050_0073;
    localparam logic [31:0] CBEQZ = 32'h0000_C001;
    localparam logic [31:0] CJR   = 32'h0000_8082;
    localparam logic [31:0] CNOP  = 32'h0000_0001;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    trace_filter_multi_window_if #(
        .INSTR_WIDTH       (32),
        .HPM_COUNTER_WIDTH (64),
        .WINDOW_WIDTH      (4),
        .STAT_WIDTH        (STAT_W)
    ) bus ();

    trace_filter_multi_window #(
        .INSTR_WIDTH       (32),
        .HPM_COUNTER_WIDTH (64),
        .WINDOW_WIDTH      (4),
        .STAT_WIDTH        (STAT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tf    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One valid instruction cycle; drop_instr is checked before the edge.
    task automatic send(input logic [31:0] ins, input logic exp_drop, input string tag,
                        input logic clr = 1'b0);
        @(negedge clk);
        bus.pc_valid    = 1'b1;
        bus.instr       = ins;
        bus.stats_clear = clr;
        #1;
        check(tag, {63'd0, bus.drop_instr}, {63'd0, exp_drop});
        @(posedge clk);
        #1;
        bus.pc_valid    = 1'b0;
        bus.stats_clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        @(negedge clk);
        bus.stats_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.stats_clear = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int exp_kept, input int exp_dropped);
        check({tag, "_kept"},    64'(bus.kept_count),    64'(exp_kept));
        check({tag, "_dropped"}, 64'(bus.dropped_count), 64'(exp_dropped));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n                 = 1'b0;
        bus.pc_valid          = 1'b0;
        bus.instr             = '0;
        bus.trap_counter      = '0;
        bus.interrupt_counter = '0;
        bus.cat_enable        = 5'h1F;
        bus.post_enable       = 5'h01;
        bus.post_count        = 4'd2;
        bus.stats_clear       = 1'b0;

        // Reset state
        idle(3);
        check("rst_drop", {63'd0, bus.drop_instr}, 64'd0);
        check_stats("rst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Post-event window of 2 after a branch
        send(BEQ, 1'b0, "win_beq");
        send(NOP, 1'b0, "win_nop1");
        send(NOP, 1'b0, "win_nop2");
        send(NOP, 1'b1, "win_nop3");
        send(NOP, 1'b1, "win_nop4");
        check_stats("win", 3, 2);

        // Overlapping window reloads to 3 at the second branch
        bus.post_count = 4'd3;
        clear_stats();
        send(BEQ, 1'b0, "ovl_beq1");
        send(NOP, 1'b0, "ovl_nop1");
        send(BEQ, 1'b0, "ovl_beq2");
        send(NOP, 1'b0, "ovl_nop2");
        send(NOP, 1'b0, "ovl_nop3");
        send(NOP, 1'b0, "ovl_nop4");
        send(NOP, 1'b1, "ovl_nop5");
        send(NOP, 1'b1, "ovl_nop6");
        check_stats("ovl", 6, 2);

        // Trap counter wrap, category enabled
        bus.post_enable = 5'h00;
        @(negedge clk);
        bus.trap_counter = 64'hFFFF_FFFF_FFFF_FFFF;
        idle(2);
        send(NOP, 1'b0, "trap_prep");
        @(negedge clk);
        bus.trap_counter = 64'h0;
        idle(4);
        send(NOP, 1'b0, "trap_wrap_kept");
        send(NOP, 1'b1, "trap_wrap_next");

        // Trap category disabled: pending is still consumed
        bus.cat_enable = 5'h17;
        @(negedge clk);
        bus.trap_counter = 64'hFFFF_FFFF_FFFF_FFFF;
        idle(2);
        send(NOP, 1'b1, "trapdis_prep");
        @(negedge clk);
        bus.trap_counter = 64'h0;
        idle(4);
        send(NOP, 1'b1, "trapdis_wrap");
        bus.cat_enable = 5'h1F;
        send(NOP, 1'b1, "trapdis_cleared");

        // Interrupt counter change
        @(negedge clk);
        bus.interrupt_counter = 64'd1;
        idle(1);
        send(NOP, 1'b0, "irq_kept");
        send(NOP, 1'b1, "irq_next");

        // Priming: nonzero counters through reset produce no event
        @(negedge clk);
        rst_n = 1'b0;
        bus.trap_counter      = 64'd5;
        bus.interrupt_counter = 64'd9;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        send(NOP, 1'b1, "prime_nop1");
        send(NOP, 1'b1, "prime_nop2");

        // Asynchronous reset in the middle of a window
        bus.post_enable = 5'h01;
        bus.post_count  = 4'd2;
        send(BEQ, 1'b0, "mid_beq");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_drop", {63'd0, bus.drop_instr}, 64'd0);
        check_stats("mid_rst", 0, 0);
        idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        send(NOP, 1'b1, "mid_after_nop");

        // Saturating dropped counter (4-bit build)
        bus.cat_enable  = 5'h00;
        bus.post_enable = 5'h00;
        clear_stats();
        for (int i = 0; i < 16; i++) begin
            send(NOP, 1'b1, "sat_fill");
        end
        check_stats("sat_full", 0, 15);
        send(NOP, 1'b1, "sat_extra");
        check_stats("sat_hold", 0, 15);
        send(NOP, 1'b1, "sat_clr", 1'b1);
        check_stats("sat_clr", 0, 0);

        // Category gating: nothing enabled, window never loads
        bus.post_enable = 5'h1F;
        bus.post_count  = 4'd7;
        send(JAL, 1'b1, "gate_jal");
        send(WFI, 1'b1, "gate_wfi");
        bus.cat_enable = 5'h1F;
        send(NOP, 1'b1, "gate_nop_after");

        // Compressed decode and single-category enables
        bus.post_enable = 5'h00;
        send(CBEQZ, 1'b0, "dec_cbeqz");
        send(CJR,   1'b0, "dec_cjr");
        send(WFI,   1'b0, "dec_wfi");
        send(CNOP,  1'b1, "dec_cnop");
        bus.cat_enable = 5'h02;
        send(BEQ, 1'b1, "dec_beq_off");
        send(JAL, 1'b0, "dec_jal_on");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
